// File: rtl/wave_register_file.sv
// Multi-wave register file: per-wave/lane-group storage, a pending-write scoreboard
// that gates reads, masked writeback, and same-cycle write-to-read bypass.
module wave_register_file #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned NUM_REGISTERS  = 32,
  parameter int unsigned LANE_WIDTH     = 16,
  parameter int unsigned WAVE_SIZE      = 32,
  parameter int unsigned NUM_WAVES      = 2,
  parameter int unsigned FIRST_WRITABLE = 4,
  localparam int unsigned CYCLES = WAVE_SIZE / LANE_WIDTH,
  localparam int unsigned RW     = $clog2(NUM_REGISTERS),
  localparam int unsigned WW     = (NUM_WAVES > 1) ? $clog2(NUM_WAVES) : 1,
  localparam int unsigned CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1,
  localparam int unsigned LW     = LANE_WIDTH * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [31:0]    block_id,
  input  logic [31:0]           block_dim,
  input  logic                  read_valid,
  output logic                  read_ready,
  input  logic [WW-1:0]         read_wave,
  input  logic [CW-1:0]         read_cycle,
  input  logic [RW-1:0]         rm,
  input  logic [RW-1:0]         rn,
  output logic                  rsp_valid,
  output logic [LW-1:0]         rm_data,
  output logic [LW-1:0]         rn_data,
  input  logic                  reserve_valid,
  input  logic [WW-1:0]         reserve_wave,
  input  logic [RW-1:0]         reserve_rd,
  input  logic                  write_valid,
  input  logic [WW-1:0]         write_wave,
  input  logic [CW-1:0]         write_cycle,
  input  logic [RW-1:0]         rd,
  input  logic [LANE_WIDTH-1:0] write_mask,
  input  logic                  write_last,
  input  logic [LW-1:0]         write_data,
  output logic                  write_err
);

  logic [LW-1:0]            mem [NUM_WAVES][CYCLES][NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0] sb  [NUM_WAVES];

  logic          write_ok_c, write_clr_c, read_acc_c;
  logic          rm_pend_c, rn_pend_c;
  logic [LW-1:0] rm_next_c, rn_next_c;

  function automatic logic writable(input logic [RW-1:0] r);
    return (r >= RW'(FIRST_WRITABLE)) && (r <= RW'(NUM_REGISTERS - 5));
  endfunction

  // Stored value for one lane, overridden by a same-cycle write and by special registers
  function automatic logic [DATA_WIDTH-1:0] lane_value(input logic [RW-1:0] r, input int unsigned i);
    logic [DATA_WIDTH-1:0] v;
    v = mem[read_wave][read_cycle][r][i*DATA_WIDTH +: DATA_WIDTH];
    if (write_ok_c && write_wave == read_wave && write_cycle == read_cycle && rd == r && write_mask[i])
      v = write_data[i*DATA_WIDTH +: DATA_WIDTH];
    if (r == RW'(NUM_REGISTERS - 4))
      v = DATA_WIDTH'(block_id);
    else if (r == RW'(NUM_REGISTERS - 3))
      v = DATA_WIDTH'(block_dim);
    else if (r == RW'(NUM_REGISTERS - 2))
      v = DATA_WIDTH'(read_wave) * DATA_WIDTH'(WAVE_SIZE)
        + DATA_WIDTH'(read_cycle) * DATA_WIDTH'(LANE_WIDTH) + DATA_WIDTH'(i);
    else if (r == RW'(NUM_REGISTERS - 1))
      v = '0;
    return v;
  endfunction

  assign write_ok_c  = write_valid && writable(rd) && (32'(write_wave) < NUM_WAVES);
  assign write_clr_c = write_ok_c && write_last;

  // A bit being cleared by this cycle's final write no longer blocks the read
  assign rm_pend_c  = sb[read_wave][rm] && !(write_clr_c && write_wave == read_wave && rd == rm);
  assign rn_pend_c  = sb[read_wave][rn] && !(write_clr_c && write_wave == read_wave && rd == rn);
  assign read_ready = (32'(read_wave) < NUM_WAVES) && !rm_pend_c && !rn_pend_c;
  assign read_acc_c = read_valid && read_ready;

  always_comb begin
    rm_next_c = '0;
    rn_next_c = '0;
    for (int unsigned i = 0; i < LANE_WIDTH; i++) begin
      rm_next_c[i*DATA_WIDTH +: DATA_WIDTH] = lane_value(rm, i);
      rn_next_c[i*DATA_WIDTH +: DATA_WIDTH] = lane_value(rn, i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < int'(NUM_WAVES); w++)
        for (int c = 0; c < int'(CYCLES); c++)
          for (int r = 0; r < int'(NUM_REGISTERS); r++)
            mem[w][c][r] <= '0;
    end else if (write_ok_c) begin
      for (int unsigned i = 0; i < LANE_WIDTH; i++)
        if (write_mask[i])
          mem[write_wave][write_cycle][rd][i*DATA_WIDTH +: DATA_WIDTH] <= write_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Reserve is applied after the clear so a same-cycle collision leaves the bit set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < int'(NUM_WAVES); w++)
        sb[w] <= '0;
    end else begin
      if (write_clr_c)
        sb[write_wave][rd] <= 1'b0;
      if (reserve_valid && writable(reserve_rd) && (32'(reserve_wave) < NUM_WAVES))
        sb[reserve_wave][reserve_rd] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      write_err <= 1'b0;
      rm_data   <= '0;
      rn_data   <= '0;
    end else begin
      rsp_valid <= read_acc_c;
      write_err <= write_valid && !write_ok_c;
      if (read_acc_c) begin
        rm_data <= rm_next_c;
        rn_data <= rn_next_c;
      end
    end
  end

endmodule

// File: tb/tb_wave_register_file.sv
// Directed bench for wave_register_file: per-thread reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_wave_register_file;
  localparam int DW = 64, NR = 32, LN = 16, WS = 32, NWV = 2;
  localparam int LW = LN * DW;

  logic              clk, rst;
  logic signed [31:0] block_id;
  logic [31:0]       block_dim;
  logic              read_valid, read_ready, rsp_valid, reserve_valid, write_valid, write_last, write_err;
  logic [0:0]        read_wave, reserve_wave, write_wave, read_cycle, write_cycle;
  logic [4:0]        rm, rn, reserve_rd, rd;
  logic [LN-1:0]     write_mask;
  logic [LW-1:0]     rm_data, rn_data, write_data;

  wave_register_file dut (
    .clk(clk), .rst(rst), .block_id(block_id), .block_dim(block_dim),
    .read_valid(read_valid), .read_ready(read_ready), .read_wave(read_wave),
    .read_cycle(read_cycle), .rm(rm), .rn(rn), .rsp_valid(rsp_valid),
    .rm_data(rm_data), .rn_data(rn_data), .reserve_valid(reserve_valid),
    .reserve_wave(reserve_wave), .reserve_rd(reserve_rd), .write_valid(write_valid),
    .write_wave(write_wave), .write_cycle(write_cycle), .rd(rd), .write_mask(write_mask),
    .write_last(write_last), .write_data(write_data), .write_err(write_err)
  );

  always #5 clk = ~clk;

  // Reference model: registers indexed by (wave, thread, reg)
  logic [63:0]   m_reg [NWV][WS][NR];
  bit            m_sb  [NWV][NR];
  logic [LW-1:0] e_rm, e_rn;
  logic          e_rsp, e_err;
  int            n_cmp, n_bad;
  bit            chk_en;

  function automatic bit wr_ok();
    return rd >= 5'd4 && rd <= 5'd27 && int'(write_wave) < NWV;
  endfunction

  function automatic bit m_pend(int w, int r);
    return m_sb[w][r] && !(write_valid && wr_ok() && write_last && int'(write_wave) == w && int'(rd) == r);
  endfunction

  function automatic bit m_ready();
    return int'(read_wave) < NWV && !m_pend(int'(read_wave), int'(rm)) && !m_pend(int'(read_wave), int'(rn));
  endfunction

  function automatic logic [63:0] m_val(int r, int lane);
    int t;
    t = int'(read_cycle) * LN + lane;
    if (r == 28) return {{32{block_id[31]}}, block_id};
    if (r == 29) return {32'd0, block_dim};
    if (r == 30) return 64'(int'(read_wave) * WS + t);
    if (r == 31) return 64'd0;
    if (write_valid && wr_ok() && write_wave == read_wave && write_cycle == read_cycle
        && int'(rd) == r && write_mask[lane])
      return write_data[lane*DW +: DW];
    return m_reg[int'(read_wave)][t][r];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < NWV; w++)
        for (int r = 0; r < NR; r++) begin
          m_sb[w][r] = 0;
          for (int t = 0; t < WS; t++) m_reg[w][t][r] = 64'd0;
        end
      e_rsp = 0; e_err = 0; e_rm = '0; e_rn = '0;
    end else begin
      e_rsp = read_valid && m_ready();
      e_err = write_valid && !wr_ok();
      if (e_rsp)
        for (int i = 0; i < LN; i++) begin
          e_rm[i*DW +: DW] = m_val(int'(rm), i);
          e_rn[i*DW +: DW] = m_val(int'(rn), i);
        end
      if (write_valid && wr_ok()) begin
        for (int i = 0; i < LN; i++)
          if (write_mask[i]) m_reg[int'(write_wave)][int'(write_cycle)*LN + i][int'(rd)] = write_data[i*DW +: DW];
        if (write_last) m_sb[int'(write_wave)][int'(rd)] = 0;
      end
      if (reserve_valid && reserve_rd >= 5'd4 && reserve_rd <= 5'd27)
        m_sb[int'(reserve_wave)][int'(reserve_rd)] = 1;
    end
  end

  task automatic cmp1(input string nm, input logic a, input logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%b required=%b", nm, $time, a, e);
    end
  endtask

  task automatic cmpv(input string nm, input logic [LW-1:0] a, input logic [LW-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      for (int i = 0; i < LN; i++)
        if (a[i*DW +: DW] !== e[i*DW +: DW]) begin
          $display("FAIL %s t=%0t lane %0d actual=%h required=%h", nm, $time, i, a[i*DW +: DW], e[i*DW +: DW]);
          break;
        end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp1("rsp_valid", rsp_valid, e_rsp);
      cmp1("write_err", write_err, e_err);
      cmp1("read_ready", read_ready, m_ready());
      cmpv("rm_data", rm_data, e_rm);
      cmpv("rn_data", rn_data, e_rn);
    end
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, a, e);
    end
  endtask

  function automatic logic [63:0] lane(input logic [LW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read_valid = 0; write_valid = 0; reserve_valid = 0; write_last = 0;
  endtask

  task automatic set_read(input int w, input int c, input int a, input int b);
    read_valid = 1; read_wave = 1'(w); read_cycle = 1'(c); rm = 5'(a); rn = 5'(b);
  endtask

  task automatic set_write(input int w, input int c, input int r, input logic [LN-1:0] msk,
                           input bit last, input logic [63:0] base);
    write_valid = 1; write_wave = 1'(w); write_cycle = 1'(c); rd = 5'(r);
    write_mask = msk; write_last = last;
    for (int i = 0; i < LN; i++) write_data[i*DW +: DW] = base + 64'(i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    clk = 0; rst = 0; n_cmp = 0; n_bad = 0; chk_en = 0;
    block_id = -32'sd2; block_dim = 32'd64;
    idle();
    read_wave = 0; read_cycle = 0; rm = 0; rn = 0;
    reserve_wave = 0; reserve_rd = 0;
    write_wave = 0; write_cycle = 0; rd = 0; write_mask = '0; write_data = '0;
    @(posedge clk);
    chk_en = 1;
    repeat (2) tick();
    rst = 1;
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rm lane0", lane(rm_data, 0), 64'd0);

    // Reset mid-operation with a read in flight
    for (int i = 0; i < LN; i++) write_data[i*DW +: DW] = 64'hA5;
    write_valid = 1; write_wave = 0; write_cycle = 0; rd = 5'd5; write_mask = 16'hFFFF;
    tick();
    idle();
    set_read(0, 0, 5, 5);
    #2 rst = 0;
    tick();
    chk("rsp after reset", 64'(rsp_valid), 64'd0);
    rst = 1;
    tick();
    chk("R5 rsp_valid", 64'(rsp_valid), 64'd1);
    chk("R5 lane0 cleared", lane(rm_data, 0), 64'd0);
    chk("R5 lane15 cleared", lane(rn_data, 15), 64'd0);
    idle();

    // Special registers
    set_read(1, 1, 28, 30);
    tick();
    chk("block_id sext", lane(rm_data, 0), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("tid lane0", lane(rn_data, 0), 64'd48);
    chk("tid lane15", lane(rn_data, 15), 64'd63);
    idle();

    // Masked write
    set_write(0, 1, 7, 16'h00FF, 0, 64'd100);
    tick();
    idle();
    set_read(0, 1, 7, 7);
    tick();
    chk("mask lane0", lane(rm_data, 0), 64'd100);
    chk("mask lane7", lane(rm_data, 7), 64'd107);
    chk("mask lane8", lane(rm_data, 8), 64'd0);
    chk("mask rn lane15", lane(rn_data, 15), 64'd0);
    idle();

    // Scoreboard stall, partial write, then final write with bypass
    reserve_valid = 1; reserve_wave = 1; reserve_rd = 5'd9;
    tick();
    reserve_valid = 0;
    set_read(1, 0, 9, 0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("sb stall", 64'(read_ready), 64'd0);
      tick();
    end
    set_write(1, 0, 9, 16'hFFFF, 0, 64'h800);
    #1 chk("sb partial", 64'(read_ready), 64'd0);
    tick();
    set_write(1, 1, 9, 16'hFFFF, 1, 64'h900);
    set_read(1, 1, 9, 9);
    #1 chk("sb release", 64'(read_ready), 64'd1);
    tick();
    chk("bypass rm lane0", lane(rm_data, 0), 64'h900);
    chk("bypass rn lane15", lane(rn_data, 15), 64'h90F);
    idle();
    set_read(1, 0, 9, 9);
    tick();
    chk("R9 c0 lane3", lane(rm_data, 3), 64'h803);
    idle();

    // Protected writes
    set_write(0, 0, 2, 16'hFFFF, 1, 64'h1234);
    tick();
    idle();
    chk("err rd2", 64'(write_err), 64'd1);
    tick();
    chk("err clears", 64'(write_err), 64'd0);
    set_write(0, 0, 29, 16'hFFFF, 0, 64'h1234);
    tick();
    idle();
    chk("err rd29", 64'(write_err), 64'd1);
    set_read(0, 0, 2, 29);
    tick();
    chk("R2 reads 0", lane(rm_data, 0), 64'd0);
    chk("R29 block_dim", lane(rn_data, 0), 64'd64);
    idle();

    // Reserve/clear collision: reserve wins
    reserve_valid = 1; reserve_wave = 0; reserve_rd = 5'd10;
    set_write(0, 0, 10, 16'hFFFF, 1, 64'h55);
    tick();
    idle();
    set_read(0, 0, 10, 10);
    #1 chk("collision pending", 64'(read_ready), 64'd0);
    set_write(0, 1, 10, 16'hFFFF, 1, 64'h66);
    set_read(0, 1, 10, 4);
    #1 chk("collision release", 64'(read_ready), 64'd1);
    tick();
    chk("R10 bypass", lane(rm_data, 0), 64'h66);
    idle();

    // Wave isolation and back-to-back reads
    set_write(1, 0, 4, 16'hFFFF, 0, 64'h44);
    tick();
    idle();
    set_read(0, 0, 4, 4);
    tick();
    chk("R4 wave0", lane(rm_data, 2), 64'd0);
    set_read(1, 0, 4, 5);
    tick();
    chk("R4 wave1", lane(rm_data, 2), 64'h46);
    idle();
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wave_register_file.md
Name: wave_register_file

Overview:
- Multi-wave, multi-lane successor to the per-lane register file.
- Stores general-purpose registers for NUM_WAVES resident waves, each WAVE_SIZE threads wide, served LANE_WIDTH lanes per access.
- Adds a per-wave pending-write scoreboard with a read handshake, per-lane write masking, and same-cycle write-to-read bypass.
- Sits between the SIMD issue stage (reads, reserves) and the ALU/memory writeback path (writes).

Parameters:
- DATA_WIDTH, 64, width of one register per thread.
- NUM_REGISTERS, 32, registers per thread; top four indices are special.
- LANE_WIDTH, 16, lanes served per access.
- WAVE_SIZE, 32, threads per wave; must be a multiple of LANE_WIDTH.
- NUM_WAVES, 2, resident waves.
- FIRST_WRITABLE, 4, lowest writable register index.
- Derived, not overridable:
  - CYCLES = WAVE_SIZE/LANE_WIDTH.
  - RW = $clog2(NUM_REGISTERS).
  - WW = max(1,$clog2(NUM_WAVES)).
  - CW = max(1,$clog2(CYCLES)).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- block_id  in  32  signed block index.
- block_dim  in  32  threads per block.
- read_valid  in  1  read request.
- read_ready  out  1  request accepted when read_valid && read_ready.
- read_wave  in  WW  wave selector.
- read_cycle  in  CW  lane group within the wave.
- rm  in  RW  source register A.
- rn  in  RW  source register B.
- rsp_valid  out  1  one-cycle pulse; read data valid.
- rm_data  out  LANE_WIDTH*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- rn_data  out  LANE_WIDTH*DATA_WIDTH  same packing.
- reserve_valid  in  1  mark a destination register pending.
- reserve_wave  in  WW  wave for the reserve.
- reserve_rd  in  RW  register for the reserve.
- write_valid  in  1  write strobe.
- write_wave  in  WW  wave for the write.
- write_cycle  in  CW  lane group for the write.
- rd  in  RW  destination register.
- write_mask  in  LANE_WIDTH  per-lane write enable.
- write_last  in  1  final lane group of this result; clears scoreboard.
- write_data  in  LANE_WIDTH*DATA_WIDTH  packed like rm_data.
- write_err  out  1  one-cycle pulse on a dropped write.

Behaviour:
- Reset (rst low, asynchronous):
  - All general-purpose storage cleared to 0.
  - All scoreboard bits cleared.
  - rsp_valid=0, write_err=0, rm_data=0, rn_data=0.
  - A request in flight at reset is discarded; no rsp_valid follows.
- Special registers (never stored, values formed at read time):
  - R[NUM_REGISTERS-4] = block_id, sign-extended to DATA_WIDTH.
  - R[NUM_REGISTERS-3] = block_dim, zero-extended.
  - R[NUM_REGISTERS-2] = thread index for lane i: read_wave*WAVE_SIZE + read_cycle*LANE_WIDTH + i, zero-extended.
  - R[NUM_REGISTERS-1] = 0.
- Writable range: FIRST_WRITABLE .. NUM_REGISTERS-5.
  - Indices 0..FIRST_WRITABLE-1 are readable, hold 0 after reset, and are never written.
- Write (write_valid=1), committed at the clock edge:
  - Updates lanes with write_mask[i]=1 of entry (write_wave, write_cycle, rd); other lanes unchanged.
  - rd outside the writable range, or write_wave >= NUM_WAVES: write dropped, write_err=1 on the next cycle, scoreboard unchanged.
  - write_last=1 on an accepted write clears scoreboard[write_wave][rd].
- Reserve (reserve_valid=1):
  - Sets scoreboard[reserve_wave][reserve_rd] at the clock edge.
  - Reserves to non-writable indices are ignored.
  - Reserve and write_last to the same (wave, reg) in the same cycle: reserve wins, bit ends set.
- read_ready (combinational): high unless rm or rn has its scoreboard bit set for read_wave.
  - Exception: a bit being cleared this cycle by a write_last write to the same (wave, reg) counts as clear.
  - Special registers are never pending.
- Read:
  - Accepted request → rm_data/rn_data registered, rsp_valid=1 exactly one cycle later. Fixed 1-cycle latency.
  - No response backpressure; one request per cycle sustained.
- Bypass:
  - If an accepted read and a valid write hit the same wave, cycle and register in the same cycle, masked lanes return write_data.
  - Unmasked lanes return the stored value.
- rm == rn is legal; both outputs carry identical data.
- Without an accepted read, rsp_valid=0 and rm_data/rn_data hold their last values.
- read_wave >= NUM_WAVES: read_ready=0.

Test Plan:
- Reset mid-operation:
  - Write R5 wave0 cycle0 lanes all = 0xA5, then pulse rst low.
  - After release, read R5 wave0 cycle0 → all lanes 0, rsp_valid one cycle after accept.
- Special registers:
  - block_id=-2, block_dim=64, read R28/R30 wave1 cycle1.
  - Required: rm_data lane0 = 0xFFFF_FFFF_FFFF_FFFE; rn_data lane i = 48+i.
- Masked write:
  - Write R7 wave0 cycle1, write_mask=0x00FF, data lane i = i+100.
  - Required: lanes 0-7 read 100-107, lanes 8-15 read 0.
- Scoreboard:
  - Reserve R9 wave1; read rm=R9 wave1 → read_ready=0 held for 3 cycles.
  - Write R9 wave1 cycle0 write_last=0 → still 0.
  - Write cycle1 write_last=1 → read_ready=1 that cycle, rsp data = bypassed write_data.
- Protected writes:
  - Write rd=2 and rd=29 → each gives write_err=1 one cycle later; reads return 0 and block_dim.
- Reserve/clear collision:
  - Reserve and write_last to R10 wave0 in the same cycle → subsequent read_ready=0 for R10.
